// File: rtl/ste_bar_decoder.sv
// Bar-graph (thermometer) input decoder: synchronizes, debounces and converts
// an LED segment code into a full-scale data value with a sticky code-error flag.
module ste_bar_decoder #(
  parameter int unsigned        DATA_W       = 12,
  parameter logic [DATA_W-1:0]  DATA_MAX     = 12'hfff,
  parameter int unsigned        LED_NR       = 8,
  parameter int unsigned        DEBOUNCE_CYC = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [LED_NR-1:0] bar_i,
  input  logic              clr_i,
  output logic [DATA_W-1:0] dout_o,
  output logic              dout_update_o,
  output logic              err_o
);

  localparam int unsigned CNT_W  = $clog2(DEBOUNCE_CYC) + 1;
  localparam int unsigned PROD_W = DATA_W + $clog2(LED_NR) + 1;
  localparam int unsigned NUM_W  = $clog2(LED_NR + 1);

  localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(DEBOUNCE_CYC - 1);
  localparam logic [PROD_W-1:0] SCALE    = PROD_W'(DATA_MAX) + PROD_W'(1);
  localparam logic [PROD_W-1:0] DIVISOR  = PROD_W'(LED_NR);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_SETTLE = 2'd1;
  localparam logic [1:0] ST_EMIT   = 2'd2;

  logic              soft_rst;
  logic [LED_NR-1:0] sync_q1;
  logic [LED_NR-1:0] sync;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic [LED_NR-1:0] acc;
  logic [LED_NR-1:0] acc_nxt;
  logic [LED_NR-1:0] cand;
  logic [LED_NR-1:0] cand_nxt;
  logic [CNT_W-1:0]  cnt;
  logic [CNT_W-1:0]  cnt_nxt;
  logic [DATA_W-1:0] dout_nxt;
  logic              upd_nxt;
  logic              err_nxt;

  logic              code_valid;
  logic [NUM_W-1:0]  ones;
  logic [PROD_W-1:0] product;
  logic [PROD_W-1:0] quotient;
  logic [DATA_W-1:0] dec_value;

  // clr_i behaves exactly like a one-cycle synchronous reset
  assign soft_rst = !rst_n || clr_i;

  // Two-flop synchronizer for the asynchronous segment inputs
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      sync_q1 <= '0;
      sync    <= '0;
    end else begin
      sync_q1 <= bar_i;
      sync    <= sync_q1;
    end
  end

  // 2^n-1 plus one has no bit in common with itself; wraps to zero for all-ones
  assign code_valid = ((cand & (cand + LED_NR'(1))) == '0);

  always_comb begin
    ones = '0;
    for (int i = 0; i < LED_NR; i++) begin
      ones = ones + NUM_W'(cand[i]);
    end
  end

  // Level n-1 scaled to full range; product fits PROD_W for any legal LED_NR
  always_comb begin
    product   = '0;
    quotient  = '0;
    dec_value = '0;
    if (ones != '0) begin
      product   = PROD_W'(ones - NUM_W'(1)) * SCALE;
      quotient  = product / DIVISOR;
      dec_value = DATA_W'(quotient);
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_nxt = state;
    acc_nxt   = acc;
    cand_nxt  = cand;
    cnt_nxt   = cnt;
    dout_nxt  = dout_o;
    upd_nxt   = 1'b0;
    err_nxt   = err_o;
    case (state)
      ST_IDLE: begin
        if (sync != acc) begin
          state_nxt = ST_SETTLE;
          cand_nxt  = sync;
          cnt_nxt   = CNT_LOAD;
        end
      end
      ST_SETTLE: begin
        if (sync != cand) begin
          cand_nxt = sync;
          cnt_nxt  = CNT_LOAD;
        end else if (cnt == '0) begin
          state_nxt = ST_EMIT;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      ST_EMIT: begin
        state_nxt = ST_IDLE;
        acc_nxt   = cand;
        // A glitch that settled back onto the accepted code is not a new value
        if (cand != acc) begin
          if (code_valid) begin
            dout_nxt = dec_value;
            upd_nxt  = 1'b1;
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (soft_rst) begin
      acc           <= '0;
      cand          <= '0;
      cnt           <= '0;
      dout_o        <= '0;
      dout_update_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      acc           <= acc_nxt;
      cand          <= cand_nxt;
      cnt           <= cnt_nxt;
      dout_o        <= dout_nxt;
      dout_update_o <= upd_nxt;
      err_o         <= err_nxt;
    end
  end

endmodule

// File: tb/tb_ste_bar_decoder.sv
// Self-checking bench for ste_bar_decoder: directed table, exact-latency
// sequences and randomized codes against a timestamp-based reference model.
module tb_ste_bar_decoder;

  localparam int unsigned DATA_W   = 12;
  localparam int          DATA_MAX = 4095;
  localparam int          LED_NR   = 8;
  localparam int          DEB      = 4;

  logic              clk;
  logic              rst_n;
  logic              clr;
  logic [LED_NR-1:0] bar;
  logic [DATA_W-1:0] dout;
  logic              upd;
  logic              err;

  ste_bar_decoder #(
    .DATA_W      (DATA_W),
    .DATA_MAX    (12'hfff),
    .LED_NR      (LED_NR),
    .DEBOUNCE_CYC(DEB)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bar_i        (bar),
    .clr_i        (clr),
    .dout_o       (dout),
    .dout_update_o(upd),
    .err_o        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors     = 0;
  int miscompares = 0;
  int pulses      = 0;
  logic prev_upd  = 1'b0;

  // Reference model state: sampled-input pipeline plus debounce timestamps
  int          cyc      = 0;
  logic [7:0]  m_s1     = '0;
  logic [7:0]  m_s2     = '0;
  logic [7:0]  m_acc    = '0;
  logic [7:0]  m_cand   = '0;
  bit          m_busy   = 0;
  bit          m_emit   = 0;
  int          m_start  = 0;
  logic [11:0] exp_dout = '0;
  logic        exp_upd  = 1'b0;
  logic        exp_err  = 1'b0;

  function automatic int thermo_level(input logic [7:0] v);
    int lvl;
    lvl = -1;
    for (int n = 0; n <= LED_NR; n++) begin
      if (int'(v) == (1 << n) - 1) lvl = n;
    end
    return lvl;
  endfunction

  task automatic model_step(input logic r, input logic c, input logic [7:0] b);
    logic [7:0] seen;
    int lvl;
    cyc++;
    if (!r || c) begin
      m_s1 = '0; m_s2 = '0; m_acc = '0; m_cand = '0;
      m_busy = 0; m_emit = 0;
      exp_dout = '0; exp_upd = 1'b0; exp_err = 1'b0;
    end else begin
      seen    = m_s2;
      exp_upd = 1'b0;
      if (m_emit) begin
        m_emit = 0;
        if (m_cand != m_acc) begin
          lvl = thermo_level(m_cand);
          if (lvl < 0) begin
            exp_err = 1'b1;
          end else begin
            exp_upd  = 1'b1;
            exp_dout = (lvl == 0) ? 12'h000 : 12'(((lvl - 1) * (DATA_MAX + 1)) / LED_NR);
          end
        end
        m_acc = m_cand;
      end else if (m_busy) begin
        if (seen != m_cand) begin
          m_cand  = seen;
          m_start = cyc;
        end else if (cyc - m_start == DEB) begin
          m_busy = 0;
          m_emit = 1;
        end
      end else if (seen != m_acc) begin
        m_busy  = 1;
        m_cand  = seen;
        m_start = cyc;
      end
      m_s2 = m_s1;
      m_s1 = b;
    end
  endtask

  task automatic step(input logic r, input logic c, input logic [7:0] b);
    rst_n = r;
    clr   = c;
    bar   = b;
    @(posedge clk);
    model_step(r, c, b);
    #1;
    vectors++;
    if (dout !== exp_dout || upd !== exp_upd || err !== exp_err) begin
      miscompares++;
      $display("FAIL model cycle %0d: dout=%h upd=%b err=%b expected dout=%h upd=%b err=%b",
               cyc, dout, upd, err, exp_dout, exp_upd, exp_err);
    end
    vectors++;
    if (upd === 1'b1 && prev_upd === 1'b1) begin
      miscompares++;
      $display("FAIL double_pulse cycle %0d: upd high two cycles running, expected single", cyc);
    end
    prev_upd = upd;
    if (upd === 1'b1) pulses++;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst_n;
    logic        clr;
    logic [7:0]  bar;
    int          cycles;
    int          pulses;
    logic [11:0] dout;
    logic        err;
  } vec_t;

  vec_t tbl[16];

  initial begin
    int   lvl;
    logic [7:0] rb;
    int   hold;
    rst_n = 1'b0;
    clr   = 1'b0;
    bar   = '0;

    tbl[0]  = '{1'b0, 1'b0, 8'h00,  2, 0, 12'h000, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 8'h07, 12, 1, 12'h400, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 8'h0F, 12, 1, 12'h600, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 8'h1F,  2, 0, 12'h600, 1'b0};
    tbl[4]  = '{1'b1, 1'b0, 8'h0F, 14, 0, 12'h600, 1'b0};
    tbl[5]  = '{1'b1, 1'b0, 8'h05, 12, 0, 12'h600, 1'b1};
    tbl[6]  = '{1'b1, 1'b0, 8'hFF, 12, 1, 12'hE00, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 8'hFF,  1, 0, 12'h000, 1'b0};
    tbl[8]  = '{1'b1, 1'b0, 8'hFF, 12, 1, 12'hE00, 1'b0};
    tbl[9]  = '{1'b1, 1'b0, 8'h00, 12, 1, 12'h000, 1'b0};
    tbl[10] = '{1'b1, 1'b0, 8'h01, 12, 1, 12'h000, 1'b0};
    tbl[11] = '{1'b1, 1'b0, 8'h3F,  4, 0, 12'h000, 1'b0};
    tbl[12] = '{1'b1, 1'b1, 8'h3F,  1, 0, 12'h000, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'h3F, 12, 1, 12'hA00, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 8'h05,  3, 0, 12'hA00, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 8'h3F, 12, 0, 12'hA00, 1'b0};

    for (int i = 0; i < 16; i++) begin
      pulses = 0;
      for (int k = 0; k < tbl[i].cycles; k++) step(tbl[i].rst_n, tbl[i].clr, tbl[i].bar);
      chk($sformatf("tbl%0d pulses", i), pulses, tbl[i].pulses);
      chk($sformatf("tbl%0d dout", i), int'(dout), int'(tbl[i].dout));
      chk($sformatf("tbl%0d err", i), int'(err), int'(tbl[i].err));
    end

    // Exact latency: pulse only in the cycle after edge E0+DEB+3
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 10; i++) begin
      step(1'b1, 1'b0, 8'h07);
      chk($sformatf("latency step%0d upd", i), int'(upd), (i == DEB + 4) ? 1 : 0);
      if (i == DEB + 4) chk("latency dout", int'(dout), 12'h400);
    end

    // Reset during EMIT aborts the pulse, then the code re-decodes
    step(1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 8'h00);
    for (int i = 1; i <= 20; i++) begin
      step((i == 8) ? 1'b0 : 1'b1, 1'b0, 8'h3F);
      chk($sformatf("emit_rst step%0d upd", i), int'(upd), (i == 16) ? 1 : 0);
      if (i == 8) chk("emit_rst err", int'(err), 0);
      if (i == 16) chk("emit_rst dout", int'(dout), 12'hA00);
    end

    // Randomized codes, hold lengths, clears and resets
    for (int s = 0; s < 400; s++) begin
      if ($urandom_range(0, 4) == 0) begin
        rb = 8'($urandom);
      end else begin
        lvl = $urandom_range(0, LED_NR);
        rb  = 8'((9'd1 << lvl) - 9'd1);
      end
      hold = $urandom_range(1, 2 * DEB + 4);
      for (int h = 0; h < hold; h++) begin
        step(($urandom_range(0, 99) != 0) ? 1'b1 : 1'b0,
             ($urandom_range(0, 59) == 0) ? 1'b1 : 1'b0, rb);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/ste_bar_decoder.md
STE_BAR_DECODER -- requirements
Module: ste_bar_decoder

Interface
REQ-001 The block SHALL have parameter DATA_W, default 12, giving the output data width.
REQ-002 The block SHALL have parameter DATA_MAX, width DATA_W, default 12'hfff, giving the full-scale data value.
REQ-003 The block SHALL have parameter LED_NR, default 8, giving the bar-graph segment count (legal range 2..16).
REQ-004 The block SHALL have parameter DEBOUNCE_CYC, default 16, giving the stability window in clk cycles (legal range >= 1).
REQ-005 The block SHALL have port clk, input, 1 bit: system clock; all logic on its rising edge.
REQ-006 The block SHALL have port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-007 The block SHALL have port bar_i, input, LED_NR bits: asynchronous bar-graph (thermometer) code; bit 0 is the lowest segment.
REQ-008 The block SHALL have port clr_i, input, 1 bit: synchronous clear.
REQ-009 The block SHALL have port dout_o, output, DATA_W bits: decoded data value, registered.
REQ-010 The block SHALL have port dout_update_o, output, 1 bit: single-cycle pulse; dout_o is new.
REQ-011 The block SHALL have port err_o, output, 1 bit: sticky flag; a non-thermometer code was accepted.

Function
REQ-012 bar_i SHALL pass through a 2-flop synchronizer; all further logic SHALL use the synchronized value (sync).
REQ-013 The FSM SHALL have three states: IDLE, SETTLE and EMIT.
REQ-014 The block SHALL hold an accepted-code register (acc, LED_NR bits), a candidate register (cand) and a down-counter (cnt) of width clog2(DEBOUNCE_CYC)+1.
REQ-015 IDLE: if sync != acc, then next state = SETTLE, cand := sync, cnt := DEBOUNCE_CYC-1; otherwise stay in IDLE.
REQ-016 SETTLE, sync != cand: cand := sync, cnt := DEBOUNCE_CYC-1 (window restart), stay in SETTLE.
REQ-017 SETTLE, sync == cand, cnt == 0: next state = EMIT.
REQ-018 SETTLE, sync == cand, cnt != 0: cnt decrements by 1.
REQ-019 EMIT SHALL last exactly one cycle: acc := cand; evaluate cand; next state = IDLE; sync is ignored during EMIT.
REQ-020 A code SHALL be valid iff cand == 2^n - 1 for some n in 0..LED_NR (contiguous ones from bit 0).
REQ-021 Valid code, n = 0: dout_o := 0 and dout_update_o pulses.
REQ-022 Valid code, n >= 1: dout_o := ((n-1) * (DATA_MAX+1)) / LED_NR and dout_update_o pulses; this is the inverse of the encoder rule segment[i] = (i <= level).
REQ-023 The arithmetic SHALL use an intermediate width of at least DATA_W + clog2(LED_NR) + 1; the result SHALL be truncated to DATA_W and never exceeds DATA_MAX.
REQ-024 Invalid code: err_o := 1, dout_o holds its value, no dout_update_o pulse; acc is still updated, so the same code is not re-evaluated.
REQ-025 dout_o and dout_update_o SHALL be registered at the EMIT-exit edge.
REQ-026 Latency: with bar_i stable from before edge E0, dout_update_o SHALL be high in exactly the one cycle following edge E0 + DEBOUNCE_CYC + 3.
REQ-027 dout_update_o SHALL never be high for two consecutive cycles.
REQ-028 A code equal to acc SHALL never produce a pulse.
REQ-029 A glitch shorter than DEBOUNCE_CYC synchronized cycles SHALL produce no pulse and no error.
REQ-030 A change arriving during EMIT SHALL be detected in the following IDLE cycle (acc != sync).
REQ-031 clr_i SHALL have the same effect as reset for one cycle; clr_i SHALL dominate all FSM events in the same cycle.
REQ-032 err_o SHALL clear only on reset or clr_i.

Reset
REQ-033 While rst_n = 0 or clr_i = 1 at a rising edge, the block SHALL set dout_o = 0, dout_update_o = 0 and err_o = 0.
REQ-034 Under the same condition, the block SHALL set state = IDLE, acc = 0, cand = 0, cnt = 0, and clear both synchronizer stages to 0.
REQ-035 Reset or clear mid-SETTLE or mid-EMIT SHALL abort the decode with no pulse; a nonzero bar_i then re-decodes after the full latency.

Verification (LED_NR=8, DATA_MAX=0xfff, DEBOUNCE_CYC=4)
REQ-036 Reset, then bar_i=0x07 held -> exactly one pulse at E0+7 with dout_o=0x400, err_o=0.
REQ-037 bar_i=0x0F, then 0x1F for 2 cycles, then 0x0F -> one pulse only, dout_o=0x600; no pulse for 0x1F.
REQ-038 bar_i=0x05 held -> err_o=1, no pulse, dout_o unchanged; then 0xFF -> pulse with dout_o=0xE00, err_o stays 1.
REQ-039 bar_i=0xFF accepted, then 0x00 -> pulse with dout_o=0; then 0x01 -> pulse with dout_o=0.
REQ-040 bar_i=0x3F, clr_i pulsed during SETTLE -> no pulse, all outputs 0; later pulse with dout_o=0xA00 at full latency after clr_i.
REQ-041 rst_n low for 1 cycle during EMIT -> no pulse in that cycle, err_o=0, redecode follows.
